ls_functional_unit: RTL and testbench

Load/store functional unit at the dispatch end of the LS reservation station. It accepts one LDUR/STUR operation per handshake from the RS: effective address on val_a, store data on val_b. It accesses a private word-addressed data memory with fixed multi-cycle latency and returns the result to the ROB as a one-cycle completion pulse tagged with the destination ROB index. Its ready output is the signal the RS samples as its LS-ready input.

---
 rtl/ls_functional_unit.sv | 145 ++++++++++++++
 tb/tb_ls_functional_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_functional_unit.sv
// Load/store FU: one LDUR/STUR in flight against a private word-addressed memory,
// LATENCY cycles accept-to-done; out_rs_ready stays low until the completion cycle.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package ls_fu_pkg;
  typedef enum logic [1:0] {
    FU_OP_LDUR = 2'd0,
    FU_OP_STUR = 2'd1
  } fu_op_t;
endpackage

module ls_functional_unit
  import ls_fu_pkg::*;
#(
  parameter int LATENCY      = 3,
  parameter int MEM_WORDS    = 64,
  parameter int MEM_IDX_SIZE = 6
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_rs_start,
  input  fu_op_t                   in_rs_op,
  input  logic [`GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [`GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [`ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                     in_rob_is_mispred,
  output logic                     out_rs_ready,
  output logic                     out_rob_done,
  output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [`GPR_SIZE-1:0]     out_rob_value,
  output logic                     out_rob_error
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [`GPR_SIZE-1:0] MEM_BYTES = `GPR_SIZE'(MEM_WORDS) << 3;

  logic [0:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  fu_op_t                   op_q, op_d;
  logic [`GPR_SIZE-1:0]     addr_q, addr_d;
  logic [`GPR_SIZE-1:0]     data_q, data_d;
  logic [`ROB_IDX_SIZE-1:0] tag_q, tag_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic [`ROB_IDX_SIZE-1:0] dst_q, dst_d;
  logic [`GPR_SIZE-1:0]     value_q, value_d;
  logic                     error_q, error_d;
  logic                     op_err;
  logic                     wr_en;
  logic [MEM_IDX_SIZE-1:0]  mem_idx;

  // Contents are architectural state: zero at power-up, never touched by reset.
  logic [`GPR_SIZE-1:0] mem_q [MEM_WORDS] = '{default: '0};

  assign mem_idx = addr_q[MEM_IDX_SIZE+2:3];
  assign op_err  = (addr_q[2:0] != 3'd0) || (addr_q >= MEM_BYTES) ||
                   !(op_q inside {FU_OP_LDUR, FU_OP_STUR});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    dst_d   = dst_q;
    value_d = value_q;
    error_d = error_q;
    wr_en   = 1'b0;
    if (state_q == IDLE) begin
      if (in_rs_start && !in_rob_is_mispred) begin
        state_d = BUSY;
        cnt_d   = 4'(LATENCY - 1);
        op_d    = in_rs_op;
        addr_d  = in_rs_val_a;
        data_d  = in_rs_val_b;
        tag_d   = in_rs_dst_rob_index;
        ready_d = 1'b0;
      end
    end else begin
      // Flush takes priority even in the completion cycle.
      if (in_rob_is_mispred) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end else if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
        dst_d   = tag_q;
        error_d = op_err;
        value_d = (!op_err && op_q == FU_OP_LDUR) ? mem_q[mem_idx] : '0;
        wr_en   = !op_err && (op_q == FU_OP_STUR);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= FU_OP_LDUR;
      addr_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dst_q   <= '0;
      value_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dst_q   <= dst_d;
      value_q <= value_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (wr_en && !in_rst) begin
      mem_q[mem_idx] <= data_q;
    end
  end

  assign out_rs_ready          = ready_q;
  assign out_rob_done          = done_q;
  assign out_rob_dst_rob_index = dst_q;
  assign out_rob_value         = value_q;
  assign out_rob_error         = error_q;
endmodule

// File: tb/tb_ls_functional_unit.sv
// Scoreboard bench for ls_functional_unit: LATENCY=3 instance with directed and
// random traffic, plus a LATENCY=1 instance for back-to-back store/load.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

module tb_ls_functional_unit;
  import ls_fu_pkg::*;

  localparam int LAT  = 3;
  localparam int LAT1 = 1;

  typedef struct {
    logic [`ROB_IDX_SIZE-1:0] tag;
    logic [63:0]              val;
    logic                     err;
    int                       due;
  } exp_t;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;

  logic                     start = 1'b0, mispred = 1'b0;
  fu_op_t                   op_s = FU_OP_LDUR;
  logic [63:0]              va = '0, vb = '0;
  logic [`ROB_IDX_SIZE-1:0] tag = '0;
  logic                     ready, done, derr;
  logic [`ROB_IDX_SIZE-1:0] dtag;
  logic [63:0]              dval;

  logic                     start1 = 1'b0, mispred1 = 1'b0;
  fu_op_t                   op1 = FU_OP_LDUR;
  logic [63:0]              va1 = '0, vb1 = '0;
  logic [`ROB_IDX_SIZE-1:0] tag1 = '0;
  logic                     ready1, done1, derr1;
  logic [`ROB_IDX_SIZE-1:0] dtag1;
  logic [63:0]              dval1;

  exp_t        q[$];
  exp_t        q1[$];
  logic [63:0] ref_mem [64];
  int          checks = 0, errors = 0, cyc = 0, last_acc = -100;
  bit          chain = 1'b0;

  ls_functional_unit #(.LATENCY(LAT), .MEM_WORDS(64), .MEM_IDX_SIZE(6)) u_dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_rs_start(start), .in_rs_op(op_s),
    .in_rs_val_a(va), .in_rs_val_b(vb), .in_rs_dst_rob_index(tag),
    .in_rob_is_mispred(mispred), .out_rs_ready(ready), .out_rob_done(done),
    .out_rob_dst_rob_index(dtag), .out_rob_value(dval), .out_rob_error(derr)
  );

  ls_functional_unit #(.LATENCY(LAT1), .MEM_WORDS(64), .MEM_IDX_SIZE(6)) u_dut1 (
    .in_clk(in_clk), .in_rst(in_rst), .in_rs_start(start1), .in_rs_op(op1),
    .in_rs_val_a(va1), .in_rs_val_b(vb1), .in_rs_dst_rob_index(tag1),
    .in_rob_is_mispred(mispred1), .out_rs_ready(ready1), .out_rob_done(done1),
    .out_rob_dst_rob_index(dtag1), .out_rob_value(dval1), .out_rob_error(derr1)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: a flat array of words, updated in program order.
  function automatic void model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] d,
                                output logic [63:0] v, output logic e);
    e = (a % 8 != 0) || (a >= 64'd512) || (o > 2'd1);
    v = '0;
    if (!e && o == 2'd0) v = ref_mem[int'(a / 8)];
    if (!e && o == 2'd1) ref_mem[int'(a / 8)] = d;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n <= 40) begin
      n++;
      @(negedge in_clk);
    end
    if (n > 40) chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  // abort_kind: 0 none, 1 mispredict, 2 reset; abort lands on edge accept+abort_at.
  task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] d,
                       input logic [`ROB_IDX_SIZE-1:0] t, input int abort_kind,
                       input int abort_at, input bit keep);
    int   k;
    exp_t e;
    wait_ready();
    start = 1'b1; op_s = fu_op_t'(o); va = a; vb = d; tag = t;
    @(negedge in_clk);
    k = cyc;
    chk("ready_low_after_accept", 64'(ready), 64'd0);
    if (chain) chk("accept_spacing", 64'(k - last_acc), 64'(LAT + 1));
    chain = keep;
    last_acc = k;
    if (!keep) start = 1'b0;
    if (abort_kind != 0) begin
      repeat (abort_at - 1) @(negedge in_clk);
      if (abort_kind == 1) mispred = 1'b1;
      else in_rst = 1'b1;
      @(negedge in_clk);
      mispred = 1'b0;
      in_rst  = 1'b0;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_no_done", 64'(done), 64'd0);
      if (abort_kind == 2) begin
        chk("rst_value", dval, 64'd0);
        chk("rst_tag", 64'(dtag), 64'd0);
        chk("rst_error", 64'(derr), 64'd0);
      end
      return;
    end
    e.tag = t;
    e.due = k + LAT;
    model(o, a, d, e.val, e.err);
    q.push_back(e);
  endtask

  always @(negedge in_clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) chk("spurious_done", 64'(done), 64'd0);
      else begin
        e = q.pop_front();
        chk("done_tag", 64'(dtag), 64'(e.tag));
        chk("done_value", dval, e.val);
        chk("done_error", 64'(derr), 64'(e.err));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge in_clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("lat1_spurious_done", 64'(done1), 64'd0);
      else begin
        e = q1.pop_front();
        chk("lat1_done_tag", 64'(dtag1), 64'(e.tag));
        chk("lat1_done_value", dval1, e.val);
        chk("lat1_done_error", 64'(derr1), 64'(e.err));
        chk("lat1_done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k1, k2;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_tag", 64'(dtag), 64'd0);
    chk("reset_value", dval, 64'd0);
    chk("reset_error", 64'(derr), 64'd0);
    chk("reset_ready_lat1", 64'(ready1), 64'd1);
    in_rst = 1'b0;
    @(negedge in_clk);

    issue(2'd1, 64'h10, 64'hDEAD_BEEF, 5, 0, 0, 1'b0);
    issue(2'd0, 64'h10, 64'h0, 6, 0, 0, 1'b0);

    // Start held high: store/load pairs to fresh words, accepts every LAT+1 cycles.
    for (int i = 0; i < 8; i++)
      issue((i % 2 == 0) ? 2'd1 : 2'd0, 64'h40 + 64'((i / 2) * 8), {$urandom, $urandom},
            `ROB_IDX_SIZE'(i), 0, 0, i != 7);

    issue(2'd0, 64'h13, 64'h0, 1, 0, 0, 1'b0);
    issue(2'd1, 64'h200, 64'h1234, 2, 0, 0, 1'b0);
    issue(2'd0, 64'h0, 64'h0, 3, 0, 0, 1'b0);

    issue(2'd1, 64'h8, 64'd7, 4, 1, 1, 1'b0);
    issue(2'd0, 64'h8, 64'h0, 5, 0, 0, 1'b0);
    issue(2'd1, 64'h8, 64'd7, 6, 1, LAT, 1'b0);
    issue(2'd0, 64'h8, 64'h0, 7, 0, 0, 1'b0);

    wait_ready();
    start = 1'b1; mispred = 1'b1; op_s = FU_OP_STUR; va = 64'h8; vb = 64'd99;
    @(negedge in_clk);
    chk("idle_flush_no_accept", 64'(ready), 64'd1);
    start = 1'b0; mispred = 1'b0;
    issue(2'd0, 64'h8, 64'h0, 8, 0, 0, 1'b0);

    issue(2'd1, 64'h20, 64'h55AA, 9, 0, 0, 1'b0);
    issue(2'd1, 64'h20, 64'h1111, 10, 2, 1, 1'b0);
    issue(2'd0, 64'h20, 64'h0, 11, 0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      int r, ak, at;
      logic [1:0] o;
      logic [63:0] a;
      r = $urandom_range(0, 19);
      o = (r < 9) ? 2'd0 : (r < 18) ? 2'd1 : 2'($urandom_range(2, 3));
      r = $urandom_range(0, 19);
      a = 64'($urandom_range(0, 15)) * 64'd8;
      if (r == 0) a = a | 64'($urandom_range(1, 7));
      else if (r == 1) a = 64'd512 + 64'($urandom_range(0, 4095));
      else if (r == 2) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      ak = ($urandom_range(0, 9) == 0) ? 1 : 0;
      at = $urandom_range(1, LAT);
      repeat ($urandom_range(0, 2)) @(negedge in_clk);
      issue(o, a, {$urandom, $urandom}, `ROB_IDX_SIZE'($urandom), ak, at, 1'b0);
    end
    repeat (LAT + 3) @(negedge in_clk);
    chk("all_completions_seen", 64'(q.size()), 64'd0);

    // LATENCY=1: store then load of the same word, start held high.
    start1 = 1'b1; op1 = FU_OP_STUR; va1 = 64'h30; vb1 = 64'hCAFE_F00D_1234_5678; tag1 = 12;
    @(negedge in_clk);
    k1 = cyc;
    q1.push_back('{`ROB_IDX_SIZE'(12), 64'd0, 1'b0, k1 + LAT1});
    chk("lat1_ready_low", 64'(ready1), 64'd0);
    op1 = FU_OP_LDUR; tag1 = 13;
    @(negedge in_clk);
    chk("lat1_ready_back", 64'(ready1), 64'd1);
    @(negedge in_clk);
    k2 = cyc;
    chk("lat1_accept_spacing", 64'(k2 - k1), 64'd2);
    q1.push_back('{`ROB_IDX_SIZE'(13), 64'hCAFE_F00D_1234_5678, 1'b0, k2 + LAT1});
    start1 = 1'b0;
    repeat (3) @(negedge in_clk);
    chk("lat1_all_completions_seen", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
